// File: rtl/axim_sched_pkg.sv
// ----------------------------------------------------------------------------
// axim_sched_pkg
// Shared types and helpers for the axim_ctrl request scheduler.
//   sched_state_e : per-channel transaction FSM states
//   idx_w()       : width of a requester index
//   slice_lo()    : low bit of slice <idx> in a packed N-slice bus
// ----------------------------------------------------------------------------
package axim_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      BUSY  = 2'd2,
      DONE  = 2'd3
   } sched_state_e;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Base bit of slice idx in a bus packed as N slices of width w, slice 0 at LSB.
   function automatic int slice_lo(input int idx, input int w);
      return idx * w;
   endfunction

endpackage

// File: rtl/axim_rr_arb.sv
// ----------------------------------------------------------------------------
// axim_rr_arb
// Round-robin arbiter. Grants the first requester at or after ptr+1
// (wrapping over exactly N entries). The pointer moves to the served index
// when i_upd is strobed, so the served requester has lowest priority next.
//   clk, rstn   : clock, async active-low reset (ptr resets to N-1)
//   i_req       : request vector
//   i_upd       : pointer update strobe
//   i_upd_idx   : index the pointer takes on update
//   o_gnt_vld   : any request present
//   o_gnt_idx   : granted index (valid when o_gnt_vld)
// ----------------------------------------------------------------------------
module axim_rr_arb
   import axim_sched_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = idx_w(N)
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic [N-1:0]  i_req,
   input  logic          i_upd,
   input  logic [IW-1:0] i_upd_idx,
   output logic          o_gnt_vld,
   output logic [IW-1:0] o_gnt_idx
);

   logic [IW-1:0] r_ptr;
   int            w_idx;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)      r_ptr <= IW'(N-1);
      else if (i_upd) r_ptr <= i_upd_idx;
   end

   // Scan from farthest to nearest so the nearest valid entry overwrites last.
   always_comb begin
      o_gnt_vld = |i_req;
      o_gnt_idx = '0;
      w_idx     = 0;
      for (int k = N; k >= 1; k--) begin
         w_idx = (int'(r_ptr) + k) % N;
         if (i_req[IW'(w_idx)]) o_gnt_idx = IW'(w_idx);
      end
   end

endmodule

// File: rtl/axim_req_sched.sv
// ----------------------------------------------------------------------------
// axim_req_sched
// Shares one axim_ctrl read engine and one write engine between C_NUM_REQ
// vector load/store requesters. Each channel has its own round-robin arbiter
// and IDLE->START->BUSY->DONE transaction FSM; the channels run concurrently.
// Ports:
//   clk, rstn                      : clock, async active-low reset
//   s_rreq_* / s_wreq_*            : per-requester request/ready/done
//   s_rd_* / s_wr_*                : per-requester stream side (steered)
//   ctrl_r* / rd_*                 : axim_ctrl read engine
//   ctrl_w* / wr_*                 : axim_ctrl write engine
// Every steered handshake and data path is forced to 0 outside BUSY, so all
// outputs are 0 while in reset.
// ----------------------------------------------------------------------------
module axim_req_sched
   import axim_sched_pkg::*;
#(
   parameter int C_NUM_REQ          = 4,
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int C_XFER_SIZE_WIDTH  = 32
) (
   input  logic                                          clk,
   input  logic                                          rstn,
   // read requests
   input  logic [C_NUM_REQ-1:0]                          s_rreq_valid,
   output logic [C_NUM_REQ-1:0]                          s_rreq_ready,
   input  logic [C_NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0]       s_rreq_addr,
   input  logic [C_NUM_REQ*C_XFER_SIZE_WIDTH-1:0]        s_rreq_size,
   output logic [C_NUM_REQ-1:0]                          s_rreq_done,
   output logic [C_NUM_REQ-1:0]                          s_rd_tvalid,
   input  logic [C_NUM_REQ-1:0]                          s_rd_tready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]                 s_rd_tdata,
   output logic                                          s_rd_tlast,
   // write requests
   input  logic [C_NUM_REQ-1:0]                          s_wreq_valid,
   output logic [C_NUM_REQ-1:0]                          s_wreq_ready,
   input  logic [C_NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0]       s_wreq_addr,
   input  logic [C_NUM_REQ*C_XFER_SIZE_WIDTH-1:0]        s_wreq_size,
   output logic [C_NUM_REQ-1:0]                          s_wreq_done,
   input  logic [C_NUM_REQ-1:0]                          s_wreq_msk_en,
   input  logic [C_NUM_REQ-1:0]                          s_wr_tvalid,
   output logic [C_NUM_REQ-1:0]                          s_wr_tready,
   input  logic [C_NUM_REQ*C_M_AXI_DATA_WIDTH-1:0]       s_wr_tdata,
   input  logic [C_NUM_REQ*C_M_AXI_DATA_WIDTH/8-1:0]     s_wr_tstrb_msk,
   // axim_ctrl read side
   output logic                                          ctrl_rstart,
   input  logic                                          ctrl_rdone,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]                 ctrl_raddr_offset,
   output logic [C_XFER_SIZE_WIDTH-1:0]                  ctrl_rxfer_size,
   input  logic                                          rd_tvalid,
   output logic                                          rd_tready,
   input  logic                                          rd_tlast,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]                 rd_tdata,
   // axim_ctrl write side
   output logic                                          ctrl_wstart,
   input  logic                                          ctrl_wdone,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]                 ctrl_waddr_offset,
   output logic [C_XFER_SIZE_WIDTH-1:0]                  ctrl_wxfer_size,
   output logic                                          ctrl_wstrb_msk_en,
   output logic                                          wr_tvalid,
   input  logic                                          wr_tready,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]               wr_tstrb_msk,
   output logic [C_M_AXI_DATA_WIDTH-1:0]                 wr_tdata
);

   localparam int N  = C_NUM_REQ;
   localparam int AW = C_M_AXI_ADDR_WIDTH;
   localparam int DW = C_M_AXI_DATA_WIDTH;
   localparam int XW = C_XFER_SIZE_WIDTH;
   localparam int SW = C_M_AXI_DATA_WIDTH / 8;
   localparam int IW = idx_w(C_NUM_REQ);

   // ------------------------------------------------------------------ read
   sched_state_e  r_rst, w_rst_nxt;
   logic [IW-1:0] r_rw;
   logic [AW-1:0] r_raddr;
   logic [XW-1:0] r_rsize;
   logic          w_rgnt_vld;
   logic [IW-1:0] w_rgnt_idx;
   logic          w_rupd;

   assign w_rupd = (r_rst == DONE);

   axim_rr_arb #(.N(N), .IW(IW)) u_rarb (
      .clk       (clk),
      .rstn      (rstn),
      .i_req     (s_rreq_valid),
      .i_upd     (w_rupd),
      .i_upd_idx (r_rw),
      .o_gnt_vld (w_rgnt_vld),
      .o_gnt_idx (w_rgnt_idx)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rst   <= IDLE;
         r_rw    <= '0;
         r_raddr <= '0;
         r_rsize <= '0;
      end else begin
         r_rst <= w_rst_nxt;
         if (r_rst == IDLE && w_rgnt_vld) begin
            r_rw    <= w_rgnt_idx;
            r_raddr <= s_rreq_addr[slice_lo(int'(w_rgnt_idx), AW) +: AW];
            r_rsize <= s_rreq_size[slice_lo(int'(w_rgnt_idx), XW) +: XW];
         end
      end
   end

   assign ctrl_raddr_offset = r_raddr;
   assign ctrl_rxfer_size   = r_rsize;

   always_comb begin
      w_rst_nxt    = r_rst;
      s_rreq_ready = '0;
      s_rreq_done  = '0;
      s_rd_tvalid  = '0;
      s_rd_tdata   = '0;
      s_rd_tlast   = 1'b0;
      rd_tready    = 1'b0;
      ctrl_rstart  = 1'b0;
      case (r_rst)
         IDLE: if (w_rgnt_vld) w_rst_nxt = START;
         START: begin
            s_rreq_ready[r_rw] = 1'b1;
            // A zero-byte transfer never touches the engine; it completes
            // on the cycle after its ready pulse.
            if (r_rsize != '0) begin
               ctrl_rstart = 1'b1;
               w_rst_nxt   = BUSY;
            end else begin
               w_rst_nxt   = DONE;
            end
         end
         BUSY: begin
            s_rd_tvalid[r_rw] = rd_tvalid;
            rd_tready         = s_rd_tready[r_rw];
            s_rd_tdata        = rd_tdata;
            s_rd_tlast        = rd_tlast;
            if (ctrl_rdone) w_rst_nxt = DONE;
         end
         DONE: begin
            s_rreq_done[r_rw] = 1'b1;
            w_rst_nxt         = IDLE;
         end
         default: w_rst_nxt = IDLE;
      endcase
   end

   // ----------------------------------------------------------------- write
   sched_state_e  r_wst, w_wst_nxt;
   logic [IW-1:0] r_ww;
   logic [AW-1:0] r_waddr;
   logic [XW-1:0] r_wsize;
   logic          r_wmsk;
   logic          w_wgnt_vld;
   logic [IW-1:0] w_wgnt_idx;
   logic          w_wupd;

   assign w_wupd = (r_wst == DONE);

   axim_rr_arb #(.N(N), .IW(IW)) u_warb (
      .clk       (clk),
      .rstn      (rstn),
      .i_req     (s_wreq_valid),
      .i_upd     (w_wupd),
      .i_upd_idx (r_ww),
      .o_gnt_vld (w_wgnt_vld),
      .o_gnt_idx (w_wgnt_idx)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wst   <= IDLE;
         r_ww    <= '0;
         r_waddr <= '0;
         r_wsize <= '0;
         r_wmsk  <= 1'b0;
      end else begin
         r_wst <= w_wst_nxt;
         if (r_wst == IDLE && w_wgnt_vld) begin
            r_ww    <= w_wgnt_idx;
            r_waddr <= s_wreq_addr[slice_lo(int'(w_wgnt_idx), AW) +: AW];
            r_wsize <= s_wreq_size[slice_lo(int'(w_wgnt_idx), XW) +: XW];
            r_wmsk  <= s_wreq_msk_en[w_wgnt_idx];
         end
      end
   end

   assign ctrl_waddr_offset = r_waddr;
   assign ctrl_wxfer_size   = r_wsize;
   assign ctrl_wstrb_msk_en = r_wmsk;

   always_comb begin
      w_wst_nxt    = r_wst;
      s_wreq_ready = '0;
      s_wreq_done  = '0;
      s_wr_tready  = '0;
      wr_tvalid    = 1'b0;
      wr_tdata     = '0;
      wr_tstrb_msk = '0;
      ctrl_wstart  = 1'b0;
      case (r_wst)
         IDLE: if (w_wgnt_vld) w_wst_nxt = START;
         START: begin
            s_wreq_ready[r_ww] = 1'b1;
            if (r_wsize != '0) begin
               ctrl_wstart = 1'b1;
               w_wst_nxt   = BUSY;
            end else begin
               w_wst_nxt   = DONE;
            end
         end
         BUSY: begin
            wr_tvalid         = s_wr_tvalid[r_ww];
            wr_tdata          = s_wr_tdata[slice_lo(int'(r_ww), DW) +: DW];
            wr_tstrb_msk      = s_wr_tstrb_msk[slice_lo(int'(r_ww), SW) +: SW];
            s_wr_tready[r_ww] = wr_tready;
            if (ctrl_wdone) w_wst_nxt = DONE;
         end
         DONE: begin
            s_wreq_done[r_ww] = 1'b1;
            w_wst_nxt         = IDLE;
         end
         default: w_wst_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_axim_req_sched.sv
// ----------------------------------------------------------------------------
// tb_axim_req_sched
// Directed bench: a vector table for round-robin grant order plus
// hand-written sequences for streaming, backpressure, concurrency,
// zero-size transfers and reset in the middle of a write.
// ----------------------------------------------------------------------------
module tb_axim_req_sched;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int XW = 32;
   localparam int SW = DW / 8;

   logic                clk = 1'b0;
   logic                rstn;
   logic [N-1:0]        s_rreq_valid, s_rreq_ready, s_rreq_done, s_rd_tvalid, s_rd_tready;
   logic [N*AW-1:0]     s_rreq_addr;
   logic [N*XW-1:0]     s_rreq_size;
   logic [DW-1:0]       s_rd_tdata;
   logic                s_rd_tlast;
   logic [N-1:0]        s_wreq_valid, s_wreq_ready, s_wreq_done, s_wreq_msk_en;
   logic [N-1:0]        s_wr_tvalid, s_wr_tready;
   logic [N*AW-1:0]     s_wreq_addr;
   logic [N*XW-1:0]     s_wreq_size;
   logic [N*DW-1:0]     s_wr_tdata;
   logic [N*SW-1:0]     s_wr_tstrb_msk;
   logic                ctrl_rstart, ctrl_rdone, rd_tvalid, rd_tready, rd_tlast;
   logic [AW-1:0]       ctrl_raddr_offset;
   logic [XW-1:0]       ctrl_rxfer_size;
   logic [DW-1:0]       rd_tdata;
   logic                ctrl_wstart, ctrl_wdone, ctrl_wstrb_msk_en, wr_tvalid, wr_tready;
   logic [AW-1:0]       ctrl_waddr_offset;
   logic [XW-1:0]       ctrl_wxfer_size;
   logic [SW-1:0]       wr_tstrb_msk;
   logic [DW-1:0]       wr_tdata;

   axim_req_sched #(
      .C_NUM_REQ(N), .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW), .C_XFER_SIZE_WIDTH(XW)
   ) dut (
      .clk(clk), .rstn(rstn),
      .s_rreq_valid(s_rreq_valid), .s_rreq_ready(s_rreq_ready), .s_rreq_addr(s_rreq_addr),
      .s_rreq_size(s_rreq_size), .s_rreq_done(s_rreq_done), .s_rd_tvalid(s_rd_tvalid),
      .s_rd_tready(s_rd_tready), .s_rd_tdata(s_rd_tdata), .s_rd_tlast(s_rd_tlast),
      .s_wreq_valid(s_wreq_valid), .s_wreq_ready(s_wreq_ready), .s_wreq_addr(s_wreq_addr),
      .s_wreq_size(s_wreq_size), .s_wreq_done(s_wreq_done), .s_wreq_msk_en(s_wreq_msk_en),
      .s_wr_tvalid(s_wr_tvalid), .s_wr_tready(s_wr_tready), .s_wr_tdata(s_wr_tdata),
      .s_wr_tstrb_msk(s_wr_tstrb_msk),
      .ctrl_rstart(ctrl_rstart), .ctrl_rdone(ctrl_rdone), .ctrl_raddr_offset(ctrl_raddr_offset),
      .ctrl_rxfer_size(ctrl_rxfer_size), .rd_tvalid(rd_tvalid), .rd_tready(rd_tready),
      .rd_tlast(rd_tlast), .rd_tdata(rd_tdata),
      .ctrl_wstart(ctrl_wstart), .ctrl_wdone(ctrl_wdone), .ctrl_waddr_offset(ctrl_waddr_offset),
      .ctrl_wxfer_size(ctrl_wxfer_size), .ctrl_wstrb_msk_en(ctrl_wstrb_msk_en),
      .wr_tvalid(wr_tvalid), .wr_tready(wr_tready), .wr_tstrb_msk(wr_tstrb_msk), .wr_tdata(wr_tdata)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic any_out();
      return |{s_rreq_ready, s_rreq_done, s_rd_tvalid, s_rd_tdata, s_rd_tlast,
               s_wreq_ready, s_wreq_done, s_wr_tready,
               ctrl_rstart, ctrl_raddr_offset, ctrl_rxfer_size, rd_tready,
               ctrl_wstart, ctrl_waddr_offset, ctrl_wxfer_size, ctrl_wstrb_msk_en,
               wr_tvalid, wr_tstrb_msk, wr_tdata};
   endfunction

   // Full read transaction on requester r; bp toggles s_rd_tready 1/0.
   task automatic do_read(input int r, input logic [31:0] a, input logic [31:0] sz,
                          input int nb, input bit bp);
      int  beat;
      int  cyc;
      bit  exp_rdy;
      s_rreq_addr[r*AW +: AW] = a;
      s_rreq_size[r*XW +: XW] = sz;
      s_rreq_valid[r] = 1'b1;
      step();
      chk("rd_ready", 64'(s_rreq_ready), 64'(1 << r));
      chk("rd_start", 64'(ctrl_rstart), 64'd1);
      chk("rd_addr", 64'(ctrl_raddr_offset), 64'(a));
      chk("rd_size", 64'(ctrl_rxfer_size), 64'(sz));
      s_rreq_valid[r] = 1'b0;
      step();
      beat = 0;
      cyc  = 0;
      while (beat < nb && cyc < 200) begin
         exp_rdy         = bp ? (cyc % 2 == 0) : 1'b1;
         rd_tvalid       = 1'b1;
         rd_tdata        = 32'hA000_0000 + 32'(beat);
         rd_tlast        = (beat == nb - 1);
         s_rd_tready[r]  = exp_rdy;
         #1;
         chk("rd_tvalid", 64'(s_rd_tvalid), 64'(1 << r));
         chk("rd_tready", 64'(rd_tready), 64'(exp_rdy));
         chk("rd_tdata", 64'(s_rd_tdata), 64'(32'hA000_0000 + 32'(beat)));
         chk("rd_tlast", 64'(s_rd_tlast), 64'(beat == nb - 1));
         if (exp_rdy) beat++;
         step();
         cyc++;
      end
      chk("rd_beats", 64'(beat), 64'(nb));
      rd_tvalid = 1'b0;
      rd_tlast  = 1'b0;
      s_rd_tready[r] = 1'b0;
      ctrl_rdone = 1'b1;
      #1;
      chk("rd_done_early", 64'(s_rreq_done), 64'd0);
      step();
      ctrl_rdone = 1'b0;
      #1;
      chk("rd_done", 64'(s_rreq_done), 64'(1 << r));
      step();
   endtask

   typedef struct {
      logic [N-1:0] vld;
      logic [31:0]  size;
      int           exp_w;
   } rr_vec_t;

   rr_vec_t tbl[12];

   initial begin
      // starting pointer is N-1 after reset
      tbl[0]  = '{4'b1111, 32'd4, 0};
      tbl[1]  = '{4'b1111, 32'd4, 1};
      tbl[2]  = '{4'b1111, 32'd4, 2};
      tbl[3]  = '{4'b1111, 32'd4, 3};
      tbl[4]  = '{4'b1111, 32'd4, 0};
      tbl[5]  = '{4'b1010, 32'd8, 1};
      tbl[6]  = '{4'b1010, 32'd8, 3};
      tbl[7]  = '{4'b0101, 32'd8, 0};
      tbl[8]  = '{4'b0100, 32'd8, 2};
      tbl[9]  = '{4'b0011, 32'd8, 0};
      tbl[10] = '{4'b1000, 32'd8, 3};
      tbl[11] = '{4'b0001, 32'd0, 0};

      rstn = 1'b0;
      s_rreq_valid = '0; s_rreq_addr = '0; s_rreq_size = '0; s_rd_tready = '0;
      s_wreq_valid = '0; s_wreq_addr = '0; s_wreq_size = '0; s_wreq_msk_en = '0;
      s_wr_tvalid = '1; s_wr_tdata = '1; s_wr_tstrb_msk = '1;
      ctrl_rdone = 1'b0; rd_tvalid = 1'b1; rd_tlast = 1'b1; rd_tdata = 32'hFFFF_FFFF;
      ctrl_wdone = 1'b0; wr_tready = 1'b1;
      #12;
      chk("reset_outs", 64'(any_out()), 64'd0);
      rd_tvalid = 1'b0; rd_tlast = 1'b0; rd_tdata = '0;
      s_wr_tvalid = '0; wr_tready = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
      step();

      // ---- round-robin table, read channel
      for (int i = 0; i < 12; i++) begin
         for (int j = 0; j < N; j++) begin
            s_rreq_addr[j*AW +: AW] = 32'h100 * 32'(j + 1);
            s_rreq_size[j*XW +: XW] = tbl[i].size;
         end
         s_rreq_valid = tbl[i].vld;
         step();
         chk($sformatf("rr%0d_ready", i), 64'(s_rreq_ready), 64'(1 << tbl[i].exp_w));
         chk($sformatf("rr%0d_start", i), 64'(ctrl_rstart), 64'(tbl[i].size != 0));
         chk($sformatf("rr%0d_addr", i), 64'(ctrl_raddr_offset), 64'(32'h100 * 32'(tbl[i].exp_w + 1)));
         if (tbl[i].size != 0) begin
            step();
            chk($sformatf("rr%0d_ready_once", i), 64'(s_rreq_ready), 64'd0);
            ctrl_rdone = 1'b1;
            step();
            ctrl_rdone = 1'b0;
         end else begin
            step();
         end
         #1;
         chk($sformatf("rr%0d_done", i), 64'(s_rreq_done), 64'(1 << tbl[i].exp_w));
         step();
      end
      s_rreq_valid = '0;
      step();

      // ---- single read, then the same read under backpressure
      do_read(0, 32'h1000, 32'd64, 16, 1'b0);
      do_read(0, 32'h2000, 32'd64, 16, 1'b1);

      // ---- concurrent read and write on requester 1
      s_rreq_addr[1*AW +: AW] = 32'h3000;  s_rreq_size[1*XW +: XW] = 32'd32;
      s_wreq_addr[1*AW +: AW] = 32'h4000;  s_wreq_size[1*XW +: XW] = 32'd32;
      s_wreq_msk_en = 4'b0010;
      for (int j = 0; j < N; j++) begin
         s_wr_tdata[j*DW +: DW]     = 32'hD000_0000 + 32'(j);
         s_wr_tstrb_msk[j*SW +: SW] = 4'hF;
      end
      s_wr_tstrb_msk[1*SW +: SW] = 4'h3;
      s_rreq_valid = 4'b0010;
      s_wreq_valid = 4'b0010;
      step();
      chk("cc_rready", 64'(s_rreq_ready), 64'b0010);
      chk("cc_wready", 64'(s_wreq_ready), 64'b0010);
      chk("cc_starts", 64'({ctrl_rstart, ctrl_wstart}), 64'b11);
      chk("cc_msk_en", 64'(ctrl_wstrb_msk_en), 64'd1);
      chk("cc_waddr", 64'(ctrl_waddr_offset), 64'h4000);
      chk("cc_wsize", 64'(ctrl_wxfer_size), 64'd32);
      s_rreq_valid = '0;
      s_wreq_valid = '0;
      step();
      s_wr_tvalid = 4'b1111;
      wr_tready   = 1'b1;
      rd_tvalid   = 1'b1;
      s_rd_tready = 4'b1111;
      #1;
      chk("cc_wr_tvalid", 64'(wr_tvalid), 64'd1);
      chk("cc_wr_tdata", 64'(wr_tdata), 64'hD000_0001);
      chk("cc_wr_strb", 64'(wr_tstrb_msk), 64'h3);
      chk("cc_s_wr_tready", 64'(s_wr_tready), 64'b0010);
      chk("cc_s_rd_tvalid", 64'(s_rd_tvalid), 64'b0010);
      s_wr_tvalid = '0; wr_tready = 1'b0; rd_tvalid = 1'b0; s_rd_tready = '0;
      ctrl_rdone = 1'b1; ctrl_wdone = 1'b1;
      step();
      ctrl_rdone = 1'b0; ctrl_wdone = 1'b0;
      #1;
      chk("cc_rdone", 64'(s_rreq_done), 64'b0010);
      chk("cc_wdone", 64'(s_wreq_done), 64'b0010);
      step();

      // ---- zero-size write from requester 2
      s_wreq_size[2*XW +: XW] = 32'd0;
      s_wreq_addr[2*AW +: AW] = 32'h5000;
      s_wreq_msk_en = '0;
      s_wreq_valid = 4'b0100;
      step();
      chk("z_ready", 64'(s_wreq_ready), 64'b0100);
      chk("z_nostart", 64'(ctrl_wstart), 64'd0);
      s_wreq_valid = '0;
      step();
      chk("z_done", 64'(s_wreq_done), 64'b0100);
      chk("z_nostart2", 64'(ctrl_wstart), 64'd0);
      step();

      // ---- reset during write BUSY, then req0 must win over req3
      s_wreq_size[3*XW +: XW] = 32'd16;
      s_wreq_addr[3*AW +: AW] = 32'h6000;
      s_wreq_valid = 4'b1000;
      step();
      chk("rs_ready", 64'(s_wreq_ready), 64'b1000);
      s_wreq_valid = '0;
      step();
      s_wr_tvalid = 4'b1111; wr_tready = 1'b1;
      #1;
      chk("rs_busy_tvalid", 64'(wr_tvalid), 64'd1);
      rstn = 1'b0;
      #1;
      chk("rs_outs_zero", 64'(any_out()), 64'd0);
      s_wr_tvalid = '0; wr_tready = 1'b0;
      step();
      rstn = 1'b1;
      step();
      s_wreq_size[0*XW +: XW] = 32'd8;
      s_wreq_addr[0*AW +: AW] = 32'h7000;
      s_wreq_valid = 4'b1001;
      step();
      chk("rs_grant0", 64'(s_wreq_ready), 64'b0001);
      chk("rs_addr0", 64'(ctrl_waddr_offset), 64'h7000);
      s_wreq_valid = 4'b1000;
      step();
      ctrl_wdone = 1'b1;
      step();
      ctrl_wdone = 1'b0;
      #1;
      chk("rs_done0", 64'(s_wreq_done), 64'b0001);
      s_wreq_valid = '0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not reach its end, expected completion");
      $fatal(1, "timeout");
   end

endmodule
